vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

VGA 640x480@60 Hz timing generator clocked at 25 MHz. It produces the raw pixel coordinates X/Y consumed by the screen renderers (border, text ROM lookup, snake layers) and the sync/blank signals for the DAC. It also provides copies of the sync and blank signals delayed by a fixed number of cycles, so they stay aligned with the registered pixel outputs of the renderers.

## Interface
- PIXEL_DISPLAY_BIT, 9: MSB index of X/Y; coordinates are PIXEL_DISPLAY_BIT+1 = 10 bits wide.
- H_SYNC, 96 / H_BP, 48 / H_ACTIVE, 640 / H_FP, 16: horizontal phase lengths in clocks; H_TOTAL = sum = 800.
- V_SYNC, 2 / V_BP, 33 / V_ACTIVE, 480 / V_FP, 10: vertical phase lengths in lines; V_TOTAL = sum = 525.
- PIPE_DELAY, 2: delay in cycles applied to the *_d outputs; legal range 1..4.

Ports:
- clock_25 in 1: pixel clock. One clock domain only.
- resetn in 1: synchronous, active-low reset.
- X out PIXEL_DISPLAY_BIT+1: horizontal counter, 0..H_TOTAL-1.
- Y out PIXEL_DISPLAY_BIT+1: vertical counter, 0..V_TOTAL-1.
- hsync_n out 1: active-low, asserted (0) iff X < H_SYNC.
- vsync_n out 1: active-low, asserted (0) iff Y < V_SYNC.
- video_on out 1: 1 iff X is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and Y is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE). Defaults: X 144..783, Y 35..514.
- frame_start out 1: 1 for exactly the cycle where X=0 and Y=0.
- hsync_n_d, vsync_n_d, video_on_d out 1 each: hsync_n, vsync_n and video_on delayed by PIPE_DELAY cycles.

## Operation
- Horizontal phase FSM: H_SYNC_S -> H_BP_S -> H_ACT_S -> H_FP_S -> H_SYNC_S.
  - Transition happens when X reaches the last count of the current phase.
  - X advances by 1 every cycle and wraps from H_TOTAL-1 to 0.
- Vertical phase FSM: V_SYNC_S -> V_BP_S -> V_ACT_S -> V_FP_S -> V_SYNC_S, same scheme as horizontal.
  - Y advances only in the cycle where X wraps to 0. Y wraps from V_TOTAL-1 to 0 on that same edge.
- hsync_n, vsync_n, video_on and frame_start are registered outputs.
  - Decode them from the next counter values so each one matches the X/Y shown in the same cycle. No one-cycle skew is allowed.
- Reset state, applied on any clock edge with resetn=0:
  - X=H_TOTAL-1, Y=V_TOTAL-1; phases H_FP_S and V_FP_S.
  - hsync_n=1, vsync_n=1, video_on=0, frame_start=0.
  - Every delay-line stage: hsync_n_d=1, vsync_n_d=1, video_on_d=0.
  - This state is consistent with the decode rules. The first cycle after release is X=0, Y=0 with frame_start=1, hsync_n=0, vsync_n=0.
- Reset asserted mid-frame: on the next edge all outputs go to the reset values and the delay line is flushed. No partial line is emitted after release.
- Width rules:
  - Counter compares are unsigned at PIXEL_DISPLAY_BIT+1 bits.
  - H_TOTAL-1 and V_TOTAL-1 must fit in that width.
  - Elaboration fails if any phase length is 0 or PIPE_DELAY is out of range.

## Timing
- Line period: H_TOTAL = 800 clocks. Frame period: H_TOTAL*V_TOTAL = 420000 clocks.
- Pulse lengths: hsync_n low for 96 consecutive clocks per line; vsync_n low for 2 lines = 1600 clocks; video_on high for 640 clocks on each of 480 lines.
- frame_start is exactly one cycle wide per frame.
- Latency:
  - X/Y and the undelayed signals: 0 cycles relative to each other.
  - *_d outputs: exactly PIPE_DELAY cycles after the undelayed signals.
- No handshake. Outputs are free-running while resetn=1.

## Structure
- Shared package vga_timing_pkg holds:
  - default timing constants (H_*, V_*), H_TOTAL and V_TOTAL;
  - the phase enum {SYNC, BP, ACT, FP}, used by both FSMs.
- Sub-module sync_delay_line: a 3-bit-wide shift register, PIPE_DELAY stages deep, with synchronous active-low reset to value {1,1,0}. Instantiated once.
- The top level holds the two counters, the two phase FSMs and the output decode.

## Test plan
- Hold resetn=0 for 3 cycles -> X=799, Y=524, hsync_n=1, vsync_n=1, video_on=0, all *_d idle. Release -> first cycle X=0, Y=0, frame_start=1, hsync_n=0, vsync_n=0.
- Run 2 lines -> hsync_n low for exactly X=0..95, falling edges 800 clocks apart. video_on=0 on lines Y=0..34. On line 35, video_on rises at X=144 and falls after X=783.
- Run 2 frames:
  - frame_start pulses exactly 420000 clocks apart;
  - vsync_n low for 1600 clocks starting at X=0, Y=0;
  - video_on high count per frame is 307200.
- PIPE_DELAY=2, then 4 -> every *_d output equals its undelayed source 2 (resp. 4) cycles earlier, checked over a full frame. Reset values are held for the first PIPE_DELAY cycles after release.
- Assert resetn=0 for 1 cycle at X=500, Y=200 -> next edge gives the reset state and *_d are flushed to idle. After release, frame_start=1 at X=0, Y=0.
- Check wrap at X=799, Y=524 -> next cycle is X=0, Y=0. At X=799, Y=100 -> next cycle is X=0, Y=101, with no Y advance at any other X.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, the phase type used by both sync
// FSMs, and the idle value of the delayed sync/blank bundle.
package vga_timing_pkg;

    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;

    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Bundle order is {hsync_n, vsync_n, video_on}: syncs released, blanked.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    typedef enum logic [1:0] {SYNC, BP, ACT, FP} phase_e;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            SYNC:    return BP;
            BP:      return ACT;
            ACT:     return FP;
            default: return SYNC;
        endcase
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that re-times the {hsync_n, vsync_n, video_on}
// bundle to line up with the renderers' registered pixel outputs.
module sync_delay_line
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clock_25,
    input  logic       resetn,
    input  logic [2:0] din,
    output logic [2:0] dout
);

    logic [2:0] stage [DEPTH];

    always_ff @(posedge clock_25) begin
        if (!resetn) begin
            // NOTE: every stage is reset, not just the head, so no stale sync survives a reset.
            for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running X/Y counters with per-axis phase FSMs,
// registered sync/blank decode and a delayed copy of sync/blank.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int PIPE_DELAY = 2
) (
    input  logic                       clock_25,
    input  logic                       resetn,
    output logic [PIXEL_DISPLAY_BIT:0] X,
    output logic [PIXEL_DISPLAY_BIT:0] Y,
    output logic                       hsync_n,
    output logic                       vsync_n,
    output logic                       video_on,
    output logic                       frame_start,
    output logic                       hsync_n_d,
    output logic                       vsync_n_d,
    output logic                       video_on_d
);

    localparam int W     = PIXEL_DISPLAY_BIT + 1;
    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Last count of each phase; the FSM advances when the counter hits it.
    localparam logic [W-1:0] H_SYNC_END = W'(H_SYNC - 1);
    localparam logic [W-1:0] H_BP_END   = W'(H_SYNC + H_BP - 1);
    localparam logic [W-1:0] H_ACT_END  = W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [W-1:0] H_LAST     = W'(H_TOT - 1);
    localparam logic [W-1:0] V_SYNC_END = W'(V_SYNC - 1);
    localparam logic [W-1:0] V_BP_END   = W'(V_SYNC + V_BP - 1);
    localparam logic [W-1:0] V_ACT_END  = W'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [W-1:0] V_LAST     = W'(V_TOT - 1);

    if (H_SYNC < 1 || H_BP < 1 || H_ACTIVE < 1 || H_FP < 1 ||
        V_SYNC < 1 || V_BP < 1 || V_ACTIVE < 1 || V_FP < 1) begin : g_bad_phase
        $error("vga_sync_gen: every phase length must be at least 1");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_delay
        $error("vga_sync_gen: PIPE_DELAY must be in 1..4");
    end
    if (H_TOT > (1 << W) || V_TOT > (1 << W)) begin : g_bad_width
        $error("vga_sync_gen: totals do not fit in the coordinate width");
    end

    phase_e       h_phase, v_phase, h_phase_next, v_phase_next;
    logic [W-1:0] h_end, v_end, x_next, y_next;
    logic         line_end;
    logic [2:0]   sync_d;

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned.
        h_end = H_LAST;
        v_end = V_LAST;
        case (h_phase)
            SYNC:    h_end = H_SYNC_END;
            BP:      h_end = H_BP_END;
            ACT:     h_end = H_ACT_END;
            default: h_end = H_LAST;
        endcase
        case (v_phase)
            SYNC:    v_end = V_SYNC_END;
            BP:      v_end = V_BP_END;
            ACT:     v_end = V_ACT_END;
            default: v_end = V_LAST;
        endcase

        line_end     = (X == H_LAST);
        x_next       = line_end ? '0 : X + 1'b1;
        h_phase_next = (X == h_end) ? next_phase(h_phase) : h_phase;
        y_next       = line_end ? ((Y == V_LAST) ? '0 : Y + 1'b1) : Y;
        v_phase_next = (line_end && Y == v_end) ? next_phase(v_phase) : v_phase;
    end

    // Outputs decode the next phase/count so they align with the X/Y they accompany.
    always_ff @(posedge clock_25) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!resetn) begin
            X           <= H_LAST;
            Y           <= V_LAST;
            h_phase     <= FP;
            v_phase     <= FP;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            X           <= x_next;
            Y           <= y_next;
            h_phase     <= h_phase_next;
            v_phase     <= v_phase_next;
            hsync_n     <= (h_phase_next != SYNC);
            vsync_n     <= (v_phase_next != SYNC);
            video_on    <= (h_phase_next == ACT) && (v_phase_next == ACT);
            frame_start <= (x_next == '0) && (y_next == '0);
        end
    end

    sync_delay_line #(
        .DEPTH(PIPE_DELAY)
    ) u_delay (
        .clock_25(clock_25),
        .resetn  (resetn),
        .din     ({hsync_n, vsync_n, video_on}),
        .dout    (sync_d)
    );

    assign {hsync_n_d, vsync_n_d, video_on_d} = sync_d;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomised-reset bench for vga_sync_gen: three instances (default timing and
// two shrunken timings) checked every cycle against a position-based model.
module tb_vga_sync_gen;

    localparam int N_DUT = 3;

    typedef struct {
        int hs, hb, ha, hf, vs, vb, va, vf, pd;
    } timing_t;

    function automatic timing_t get_cfg(input int i);
        case (i)
            0:       return '{96, 48, 640, 16, 2, 33, 480, 10, 2};
            1:       return '{6, 4, 16, 3, 2, 3, 8, 2, 4};
            default: return '{3, 2, 5, 2, 1, 2, 4, 1, 2};
        endcase
    endfunction

    function automatic int h_total(input timing_t c);
        return c.hs + c.hb + c.ha + c.hf;
    endfunction

    function automatic int f_total(input timing_t c);
        return h_total(c) * (c.vs + c.vb + c.va + c.vf);
    endfunction

    // {hsync_n, vsync_n, video_on, frame_start} at linear frame position p
    function automatic logic [3:0] model_out(input timing_t c, input int p);
        int x, y;
        logic hx, vy;
        x  = p % h_total(c);
        y  = p / h_total(c);
        hx = (x >= c.hs + c.hb) && (x < c.hs + c.hb + c.ha);
        vy = (y >= c.vs + c.vb) && (y < c.vs + c.vb + c.va);
        return {x >= c.hs, y >= c.vs, hx && vy, p == 0};
    endfunction

    logic clock_25 = 1'b0;
    logic resetn   = 1'b0;
    always #20 clock_25 = ~clock_25;

    logic [9:0] ox [N_DUT];
    logic [9:0] oy [N_DUT];
    logic ohs [N_DUT], ovs [N_DUT], ovid [N_DUT], ofs [N_DUT];
    logic ohsd [N_DUT], ovsd [N_DUT], ovidd [N_DUT];

    vga_sync_gen #(
        .PIXEL_DISPLAY_BIT(9),
        .H_SYNC(96), .H_BP(48), .H_ACTIVE(640), .H_FP(16),
        .V_SYNC(2), .V_BP(33), .V_ACTIVE(480), .V_FP(10),
        .PIPE_DELAY(2)
    ) u_dut0 (
        .clock_25(clock_25), .resetn(resetn), .X(ox[0]), .Y(oy[0]),
        .hsync_n(ohs[0]), .vsync_n(ovs[0]), .video_on(ovid[0]), .frame_start(ofs[0]),
        .hsync_n_d(ohsd[0]), .vsync_n_d(ovsd[0]), .video_on_d(ovidd[0])
    );

    vga_sync_gen #(
        .PIXEL_DISPLAY_BIT(9),
        .H_SYNC(6), .H_BP(4), .H_ACTIVE(16), .H_FP(3),
        .V_SYNC(2), .V_BP(3), .V_ACTIVE(8), .V_FP(2),
        .PIPE_DELAY(4)
    ) u_dut1 (
        .clock_25(clock_25), .resetn(resetn), .X(ox[1]), .Y(oy[1]),
        .hsync_n(ohs[1]), .vsync_n(ovs[1]), .video_on(ovid[1]), .frame_start(ofs[1]),
        .hsync_n_d(ohsd[1]), .vsync_n_d(ovsd[1]), .video_on_d(ovidd[1])
    );

    vga_sync_gen #(
        .PIXEL_DISPLAY_BIT(9),
        .H_SYNC(3), .H_BP(2), .H_ACTIVE(5), .H_FP(2),
        .V_SYNC(1), .V_BP(2), .V_ACTIVE(4), .V_FP(1),
        .PIPE_DELAY(2)
    ) u_dut2 (
        .clock_25(clock_25), .resetn(resetn), .X(ox[2]), .Y(oy[2]),
        .hsync_n(ohs[2]), .vsync_n(ovs[2]), .video_on(ovid[2]), .frame_start(ofs[2]),
        .hsync_n_d(ohsd[2]), .vsync_n_d(ovsd[2]), .video_on_d(ovidd[2])
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: linear frame position per instance plus a history of undelayed outputs.
    int         pos  [N_DUT];
    logic [2:0] hist [N_DUT][$];
    bit         model_ok = 1'b0;
    bit         rst_seen = 1'b0;

    always @(posedge clock_25) begin
        for (int i = 0; i < N_DUT; i++) begin
            timing_t    c;
            logic [3:0] e;
            c = get_cfg(i);
            if (!resetn) begin
                pos[i] = f_total(c) - 1;
                hist[i].delete();
                for (int k = 0; k <= c.pd; k++) hist[i].push_front(3'b110);
            end else if (model_ok) begin
                pos[i] = (pos[i] + 1) % f_total(c);
                e = model_out(c, pos[i]);
                hist[i].push_front(e[3:1]);
                void'(hist[i].pop_back());
            end
        end
        if (!resetn) begin
            model_ok = 1'b1;
            rst_seen = 1'b1;
        end
    end

    always @(negedge clock_25) begin
        if (model_ok) begin
            for (int i = 0; i < N_DUT; i++) begin
                timing_t    c;
                logic [3:0] e;
                logic [2:0] d;
                c = get_cfg(i);
                e = model_out(c, pos[i]);
                d = hist[i][c.pd];
                check($sformatf("u%0d X", i), ox[i], pos[i] % h_total(c));
                check($sformatf("u%0d Y", i), oy[i], pos[i] / h_total(c));
                check($sformatf("u%0d hsync_n", i), ohs[i], e[3]);
                check($sformatf("u%0d vsync_n", i), ovs[i], e[2]);
                check($sformatf("u%0d video_on", i), ovid[i], e[1]);
                check($sformatf("u%0d frame_start", i), ofs[i], e[0]);
                check($sformatf("u%0d hsync_n_d", i), ohsd[i], d[2]);
                check($sformatf("u%0d vsync_n_d", i), ovsd[i], d[1]);
                check($sformatf("u%0d video_on_d", i), ovidd[i], d[0]);
            end
        end
    end

    // Interval checks: frame period/totals on u1, hsync period/width on u0.
    int cyc = 0;
    int last_fs = -1, vid_cnt = 0, vs_cnt = 0;
    int last_fall = -1, low_run = 0;
    logic prev_hs = 1'b1;

    always @(negedge clock_25) begin
        if (rst_seen) begin
            rst_seen  = 1'b0;
            last_fs   = -1;
            vid_cnt   = 0;
            vs_cnt    = 0;
            last_fall = -1;
            low_run   = 0;
            prev_hs   = 1'b1;
        end
        cyc++;
        if (model_ok && resetn) begin
            if (ofs[1]) begin
                if (last_fs >= 0) begin
                    check("u1 frame period", cyc - last_fs, 435);
                    check("u1 video_on per frame", vid_cnt, 16 * 8);
                    check("u1 vsync low per frame", vs_cnt, 2 * 29);
                end
                last_fs = cyc;
                vid_cnt = 0;
                vs_cnt  = 0;
            end
            if (ovid[1]) vid_cnt++;
            if (!ovs[1]) vs_cnt++;

            if (prev_hs && !ohs[0]) begin
                if (last_fall >= 0) check("u0 hsync period", cyc - last_fall, 800);
                last_fall = cyc;
                low_run   = 0;
            end
            if (!ohs[0]) low_run++;
            if (!prev_hs && ohs[0]) check("u0 hsync low width", low_run, 96);
            prev_hs = ohs[0];
        end
    end

    initial begin
        bit found;
        resetn = 1'b0;
        repeat (3) @(negedge clock_25);
        resetn = 1'b1;
        // Enough for u0 to pass line 35 and for u1/u2 to run many frames.
        repeat (30000) @(negedge clock_25);

        for (int r = 0; r < 5; r++) begin
            resetn = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clock_25);
            resetn = 1'b1;
            repeat ($urandom_range(200, 2000)) @(negedge clock_25);
        end

        // Single-cycle reset mid-frame on u1 at X=20, Y=10.
        found = 1'b0;
        for (int k = 0; k < 2 * 435 && !found; k++) begin
            @(negedge clock_25);
            if (ox[1] == 10'd20 && oy[1] == 10'd10) found = 1'b1;
        end
        check("u1 reach X20 Y10", found, 1);
        resetn = 1'b0;
        @(negedge clock_25);
        resetn = 1'b1;
        repeat (2000) @(negedge clock_25);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
